hard_decision_unit: RTL and testbench

Downstream stage of the turbo decoder core. It consumes the per-iteration 7×10-bit a-posteriori LLR word from the final de-interleaved SISO output and slices it into a 5-bit hard-decision word, discarding the 2 tail bits. It tracks decisions across iterations and requests early termination once they are stable and confident. Emitted words are buffered in a small valid/ready output FIFO.

---
 rtl/hard_decision_unit.sv | 182 ++++++++++++++++++
 tb/tb_hard_decision_unit.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/hard_decision_unit.sv
// Hard-decision slicer for the turbo decoder back end.
// Turns each a-posteriori LLR word into info-bit decisions and watches those
// decisions across iterations. Once they are stable and confident it asks the
// decoder to stop early. Emitted words wait in a small valid/ready FIFO.
module hard_decision_unit #(
  parameter int LLR_W        = 10,
  parameter int N_EXT        = 7,
  parameter int N_INFO       = 5,
  parameter int STABLE_ITERS = 2,
  parameter int CONF_THR     = 16,
  parameter int FIFO_DEPTH   = 2   // power of 2, at least 2
) (
  input  logic                     clk_p_i,
  input  logic                     reset_n_i,
  input  logic                     block_start_i,
  input  logic                     llr_valid_i,
  input  logic [N_EXT*LLR_W-1:0]   llr_i,
  input  logic                     last_iter_i,
  output logic                     stop_o,
  output logic [N_INFO-1:0]        data_o,
  output logic                     data_valid_o,
  input  logic                     data_ready_i,
  output logic                     overflow_o
);

  localparam int MAG_W  = LLR_W - 1;
  localparam int CNT_W  = $clog2(STABLE_ITERS + 1);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int FCNT_W = PTR_W + 1;

  typedef enum logic {S_IDLE, S_TRACK} state_t;

  // ---------------------------------------------------------------------------
  // Slicing and confidence, info elements only
  // ---------------------------------------------------------------------------
  logic [N_INFO-1:0] dec;
  logic [N_INFO-1:0] conf_bit;
  logic              conf;

  for (genvar gi = 0; gi < N_INFO; gi++) begin : g_slice
    logic [LLR_W-1:0] elem;
    logic [LLR_W-1:0] neg;
    logic [MAG_W-1:0] mag;
    assign elem = llr_i[LLR_W*gi +: LLR_W];
    assign neg  = ~elem + 1'b1;
    // Strictly positive: sign clear and not zero.
    assign dec[gi] = ~elem[LLR_W-1] & (|elem);
    // Only the most negative value overflows on negation; clamp it to max.
    assign mag = ~elem[LLR_W-1] ? elem[MAG_W-1:0]
               : (neg[LLR_W-1] ? {MAG_W{1'b1}} : neg[MAG_W-1:0]);
    assign conf_bit[gi] = (mag >= MAG_W'(CONF_THR));
  end

  assign conf = &conf_bit;

  // Tail LLRs carry no information for this stage.
  logic unused_tail;
  assign unused_tail = ^llr_i[N_EXT*LLR_W-1:N_INFO*LLR_W];

  // ---------------------------------------------------------------------------
  // Tracking FSM
  // ---------------------------------------------------------------------------
  state_t            state_q, state_d;
  logic [N_INFO-1:0] prev_dec_q, prev_dec_d;
  logic [CNT_W-1:0]  match_cnt_q, match_cnt_d;
  logic [CNT_W-1:0]  nxt_cnt;
  logic              stop_q, stop_d;
  logic              push;

  // Next-state and emit decision for the current input word.
  always_comb begin
    state_d     = state_q;
    prev_dec_d  = prev_dec_q;
    match_cnt_d = match_cnt_q;
    stop_d      = 1'b0;
    push        = 1'b0;
    nxt_cnt     = ((dec == prev_dec_q) && conf) ? match_cnt_q + CNT_W'(1) : '0;
    if (block_start_i) begin
      // Abort wins over any word arriving in the same cycle.
      state_d     = S_IDLE;
      match_cnt_d = '0;
    end else if (llr_valid_i) begin
      prev_dec_d = dec;
      case (state_q)
        S_IDLE: begin
          match_cnt_d = '0;
          if (last_iter_i) begin
            push = 1'b1;
          end else begin
            state_d = S_TRACK;
          end
        end
        default: begin
          if (nxt_cnt == CNT_W'(STABLE_ITERS)) begin
            // Stability takes priority over the last-iteration exit.
            push        = 1'b1;
            stop_d      = 1'b1;
            state_d     = S_IDLE;
            match_cnt_d = '0;
          end else if (last_iter_i) begin
            push        = 1'b1;
            state_d     = S_IDLE;
            match_cnt_d = '0;
          end else begin
            match_cnt_d = nxt_cnt;
          end
        end
      endcase
    end
  end

  // FSM state and registered stop pulse.
  always_ff @(posedge clk_p_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= S_IDLE;
      prev_dec_q  <= '0;
      match_cnt_q <= '0;
      stop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_dec_q  <= prev_dec_d;
      match_cnt_q <= match_cnt_d;
      stop_q      <= stop_d;
    end
  end

  assign stop_o = stop_q;

  // ---------------------------------------------------------------------------
  // Output FIFO
  // ---------------------------------------------------------------------------
  logic [N_INFO-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [FCNT_W-1:0] count_q;
  logic [N_INFO-1:0] last_q;
  logic              overflow_q;
  logic              pop, full, do_push;

  assign pop     = (count_q != '0) && data_ready_i;
  assign full    = (count_q == FCNT_W'(FIFO_DEPTH));
  assign do_push = push && (!full || pop);

  // Storage array; no reset needed since reads are qualified by count_q.
  always_ff @(posedge clk_p_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= dec;
    end
  end

  // Pointers, occupancy, last-popped word and sticky overflow.
  always_ff @(posedge clk_p_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      last_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        last_q   <= mem_q[rd_ptr_q];
      end
      if (do_push && !pop) begin
        count_q <= count_q + FCNT_W'(1);
      end else if (pop && !do_push) begin
        count_q <= count_q - FCNT_W'(1);
      end
      if (push && !do_push) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // When empty, keep showing the most recently consumed word.
  assign data_o       = (count_q != '0) ? mem_q[rd_ptr_q] : last_q;
  assign data_valid_o = (count_q != '0);
  assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_hard_decision_unit.sv
// Scoreboard bench for hard_decision_unit: the driver queues expected words,
// a negedge monitor compares each word as the consumer takes it.
module tb_hard_decision_unit;
  localparam int LLR_W  = 10;
  localparam int N_EXT  = 7;
  localparam int N_INFO = 5;
  localparam int W      = N_EXT * LLR_W;

  logic              clk_p_i = 1'b0;
  logic              reset_n_i = 1'b0;
  logic              block_start_i = 1'b0;
  logic              llr_valid_i = 1'b0;
  logic [W-1:0]      llr_i = '0;
  logic              last_iter_i = 1'b0;
  logic              stop_o;
  logic [N_INFO-1:0] data_o;
  logic              data_valid_o;
  logic              data_ready_i = 1'b0;
  logic              overflow_o;

  hard_decision_unit dut (
    .clk_p_i       (clk_p_i),
    .reset_n_i     (reset_n_i),
    .block_start_i (block_start_i),
    .llr_valid_i   (llr_valid_i),
    .llr_i         (llr_i),
    .last_iter_i   (last_iter_i),
    .stop_o        (stop_o),
    .data_o        (data_o),
    .data_valid_o  (data_valid_o),
    .data_ready_i  (data_ready_i),
    .overflow_o    (overflow_o)
  );

  always #5 clk_p_i = ~clk_p_i;

  int                n_tests = 0;
  int                n_fail  = 0;
  logic [N_INFO-1:0] exp_q[$];
  logic              exp_stop = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: stop_o every cycle, data on each accepted transfer.
  always @(negedge clk_p_i) begin
    if (reset_n_i) begin
      chk("stop_o", {31'd0, stop_o}, {31'd0, exp_stop});
      if (data_valid_o && data_ready_i) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", {27'd0, data_o}, 32'hFFFF_FFFF);
        end else begin
          logic [N_INFO-1:0] e;
          e = exp_q.pop_front();
          chk("data_o", {27'd0, data_o}, {27'd0, e});
          $display("[TB] word %05b popped (expected %05b)", data_o, e);
        end
      end
    end
  end

  // Word with info bits +m/-m according to bits, tails -300.
  function automatic logic [W-1:0] mk(input logic [N_INFO-1:0] bits, input int m);
    logic [W-1:0] w;
    int t;
    for (int k = 0; k < N_EXT; k++) begin
      if (k < N_INFO) t = bits[k] ? m : -m;
      else t = -300;
      w[k*LLR_W +: LLR_W] = t[LLR_W-1:0];
    end
    return w;
  endfunction

  function automatic logic [W-1:0] mk5(input int a0, input int a1, input int a2,
                                       input int a3, input int a4);
    logic [W-1:0] w;
    int v[N_EXT];
    v = '{a0, a1, a2, a3, a4, -300, -300};
    for (int k = 0; k < N_EXT; k++) begin
      int t;
      t = v[k];
      w[k*LLR_W +: LLR_W] = t[LLR_W-1:0];
    end
    return w;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_p_i); #1;
      exp_stop = 1'b0;
    end
  endtask

  task automatic send(input logic [W-1:0] w, input logic last, input logic es,
                      input logic emit, input logic [N_INFO-1:0] exp_d, input logic bs);
    llr_i = w; llr_valid_i = 1'b1; last_iter_i = last; block_start_i = bs;
    if (emit) exp_q.push_back(exp_d);
    @(posedge clk_p_i); #1;
    llr_valid_i = 1'b0; last_iter_i = 1'b0; block_start_i = 1'b0;
    exp_stop = es;
  endtask

  logic [W-1:0] a_w;

  initial begin
    a_w = mk(5'b10101, 100);
    // Reset state
    #3;
    chk("rst_stop", {31'd0, stop_o}, 0);
    chk("rst_valid", {31'd0, data_valid_o}, 0);
    chk("rst_data", {27'd0, data_o}, 0);
    chk("rst_ovf", {31'd0, overflow_o}, 0);
    tick(2);
    reset_n_i = 1'b1;
    data_ready_i = 1'b1;
    tick(1);

    // Early stop after three matching confident words
    send(a_w, 0, 0, 0, 5'd0, 0);
    send(a_w, 0, 0, 0, 5'd0, 0);
    send(a_w, 0, 1, 1, 5'b10101, 0);
    chk("early_valid_hi", {31'd0, data_valid_o}, 1);
    tick(1);
    chk("early_valid_lo", {31'd0, data_valid_o}, 0);
    tick(2);

    // Low confidence: element 2 = -8 slices to 0 and fails the threshold
    for (int i = 0; i < 5; i++) send(mk5(100, -100, -8, -100, 100), 0, 0, 0, 5'd0, 0);
    send(mk5(100, -100, -8, -100, 100), 1, 0, 1, 5'b10001, 0);
    tick(3);

    // Zero / saturation from IDLE
    send(mk5(0, -512, 1, 511, -1), 1, 0, 1, 5'b01100, 0);
    tick(3);

    // Stability wins over last iteration
    send(a_w, 0, 0, 0, 5'd0, 0);
    send(a_w, 0, 0, 0, 5'd0, 0);
    send(a_w, 1, 1, 1, 5'b10101, 0);
    tick(3);

    // Backpressure / overflow
    data_ready_i = 1'b0;
    send(mk(5'h01, 50), 1, 0, 1, 5'h01, 0);
    send(mk(5'h02, 50), 1, 0, 1, 5'h02, 0);
    send(mk(5'h03, 50), 1, 0, 0, 5'd0, 0);
    tick(1);
    chk("ovf_sticky", {31'd0, overflow_o}, 1);
    chk("ovf_valid", {31'd0, data_valid_o}, 1);
    chk("ovf_head", {27'd0, data_o}, 5'h01);
    data_ready_i = 1'b1;
    tick(4);
    chk("drain_valid", {31'd0, data_valid_o}, 0);
    chk("drain_hold", {27'd0, data_o}, 5'h02);
    chk("ovf_still", {31'd0, overflow_o}, 1);

    // Abort during TRACK with coincident word
    send(a_w, 0, 0, 0, 5'd0, 0);
    send(a_w, 0, 0, 0, 5'd0, 0);
    send(a_w, 0, 0, 0, 5'd0, 1);
    send(a_w, 0, 0, 0, 5'd0, 0);
    send(a_w, 0, 0, 0, 5'd0, 0);
    send(a_w, 0, 1, 1, 5'b10101, 0);
    tick(3);

    // Reset mid-operation: one word stored, TRACK with match count 1
    data_ready_i = 1'b0;
    send(mk(5'h1F, 60), 1, 0, 1, 5'h1F, 0);
    send(a_w, 0, 0, 0, 5'd0, 0);
    send(a_w, 0, 0, 0, 5'd0, 0);
    #2;
    reset_n_i = 1'b0;
    #1;
    exp_q.delete();
    chk("mid_rst_valid", {31'd0, data_valid_o}, 0);
    chk("mid_rst_data", {27'd0, data_o}, 0);
    chk("mid_rst_stop", {31'd0, stop_o}, 0);
    chk("mid_rst_ovf", {31'd0, overflow_o}, 0);
    tick(1);
    reset_n_i = 1'b1;
    data_ready_i = 1'b1;
    tick(1);
    send(a_w, 0, 0, 0, 5'd0, 0);
    send(a_w, 0, 0, 0, 5'd0, 0);
    send(a_w, 0, 1, 1, 5'b10101, 0);
    tick(3);

    chk("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
